usr_burst_shifter: RTL
======================

Name: usr_burst_shifter

Overview:
- Parametrised universal shift register, WIDTH bits wide, with eight modes: hold, logical shift, rotate, arithmetic shift, parallel load and clear.
- Adds a burst engine: one command performs up to WIDTH shift/rotate steps autonomously, with busy/done handshake.
- Used as the serialiser/deserialiser and barrel-step stage behind the datapath registers; generalises the existing 4-bit hold/shift/load register.

Parameters:
- WIDTH, 8, register width in bits (>= 2).
- CNT_W, $clog2(WIDTH+1), width of burst_len and the internal step counter (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  execute `mode` for one step this cycle (IDLE only).
- mode  in  3  operation select (see Behaviour).
- in  in  WIDTH  parallel load data.
- sir  in  1  serial in, enters the MSB on right shift.
- sil  in  1  serial in, enters bit 0 on left shift.
- burst_start  in  1  request a multi-step burst of `mode` (IDLE only).
- burst_len  in  CNT_W  number of steps for the burst, 0..WIDTH.
- out  out  WIDTH  register contents.
- so_right  out  1  equals out[0].
- so_left  out  1  equals out[WIDTH-1].
- busy  out  1  high while a burst is running.
- done  out  1  one-cycle pulse after a burst completes.

Behaviour:
- Reset (reset=0, asynchronous):
  - out = 0, busy = 0, done = 0.
  - FSM = IDLE, step counter = 0, latched mode = 0.
  - Reset mid-burst aborts the burst with no done pulse.
- Mode encoding (one step):
  - 0 hold.
  - 1 SHR: {sir, out[W-1:1]}.
  - 2 SHL: {out[W-2:0], sil}.
  - 3 LOAD: in.
  - 4 ROR: {out[0], out[W-1:1]}.
  - 5 ROL: {out[W-2:0], out[W-1]}.
  - 6 ASR: {out[W-1], out[W-1:1]}.
  - 7 CLEAR: 0.
- IDLE state:
  - burst_start has priority over en.
  - burst_start=1 with mode in {1,2,4,5,6} and burst_len>=1: latch mode and burst_len; out unchanged this edge; next state BURST, busy=1 from the next cycle.
  - burst_start=1 with burst_len=0 and a burstable mode: no step; done=1 next cycle; stay IDLE.
  - burst_start=1 with a non-burstable mode (0, 3, 7): ignored entirely; en is also ignored that cycle.
  - Otherwise, if en=1: one step of `mode` at the edge, so out updates one cycle after en. No done pulse.
- BURST state:
  - Each edge performs one step of the latched mode and decrements the counter.
  - sir/sil are sampled live every step.
  - On the step where the counter goes 1 -> 0: next state IDLE, busy=0 and done=1 in the following cycle. done lasts exactly 1 cycle.
  - en, mode, burst_start and burst_len are ignored while busy=1.
  - A burst of N steps keeps busy high for exactly N cycles.
- A new burst_start in the cycle where done=1 is accepted, because the FSM is already in IDLE.
- burst_len > WIDTH is clamped to WIDTH.
- Outputs are registered, except so_right/so_left, which are direct wires from out.

Decomposition:
- Shared package usr_pkg:
  - Mode localparams: USR_HOLD, USR_SHR, USR_SHL, USR_LOAD, USR_ROR, USR_ROL, USR_ASR, USR_CLR.
  - FSM state enum: ST_IDLE, ST_BURST.
  - Function is_burstable(mode).
- Sub-module usr_step_logic: combinational next-value function (out, mode, in, sir, sil) -> next. Shared by the single-step and burst paths.
- The top level holds the FSM, counter and register.

Test Plan:
- Reset, then en=1, mode=3, in=8'hA5 -> out=8'hA5 one cycle later; reset low asynchronously mid-cycle -> out=0 immediately.
- out=8'hA5, en=1, mode=1, sir=1 for 2 cycles -> 8'hD2, then 8'hE9; mode=2, sil=0 once -> 8'hD2.
- out=8'h81, burst_start, mode=4, len=3 -> busy high 3 cycles, out=8'h30, done pulses 1 cycle, busy low.
- out=8'h80, burst mode=6, len=WIDTH (8) -> out=8'hFF; en/mode toggled during burst have no effect.
- burst_start with len=0 -> done pulse next cycle, out unchanged; burst_start with mode=3 -> ignored, no done, en suppressed.
- reset asserted at step 2 of a len=5 burst -> out=0, busy=0, no done pulse; new burst accepted in the cycle done=1 of a prior burst.

Source files
------------

// File: rtl/usr_pkg.sv
// usr_pkg: shared mode codes, FSM states and helpers for the burst shift register
package usr_pkg;
   localparam logic [2:0] USR_HOLD = 3'd0;
   localparam logic [2:0] USR_SHR  = 3'd1;
   localparam logic [2:0] USR_SHL  = 3'd2;
   localparam logic [2:0] USR_LOAD = 3'd3;
   localparam logic [2:0] USR_ROR  = 3'd4;
   localparam logic [2:0] USR_ROL  = 3'd5;
   localparam logic [2:0] USR_ASR  = 3'd6;
   localparam logic [2:0] USR_CLR  = 3'd7;

   typedef enum logic {ST_IDLE, ST_BURST} usr_state_t;

   // Only the movement modes make sense to repeat; hold/load/clear are single-shot
   function automatic logic is_burstable(input logic [2:0] m);
      return m inside {USR_SHR, USR_SHL, USR_ROR, USR_ROL, USR_ASR};
   endfunction
endpackage

// File: rtl/usr_step_logic.sv
// usr_step_logic: one-step next value of the shift register for a given mode
//   cur  - current register value      mode - operation select
//   din  - parallel load data          sir/sil - serial in for right/left shift
//   nxt  - register value after one step
module usr_step_logic
   import usr_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] cur,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] din,
   input  logic             sir,
   input  logic             sil,
   output logic [WIDTH-1:0] nxt
);
   always_comb begin
      nxt = cur;
      case (mode)
         USR_SHR:  nxt = {sir, cur[WIDTH-1:1]};
         USR_SHL:  nxt = {cur[WIDTH-2:0], sil};
         USR_LOAD: nxt = din;
         USR_ROR:  nxt = {cur[0], cur[WIDTH-1:1]};
         USR_ROL:  nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
         USR_ASR:  nxt = {cur[WIDTH-1], cur[WIDTH-1:1]};
         USR_CLR:  nxt = '0;
         default:  nxt = cur;
      endcase
   end
endmodule

// File: rtl/usr_burst_shifter.sv
// usr_burst_shifter: universal shift register with an autonomous multi-step burst engine
//   clk, reset (async, active low)
//   en, mode, in, sir, sil      - single-step control and data
//   burst_start, burst_len      - start a burst of up to WIDTH steps of mode
//   out, so_right, so_left      - register contents and serial outs
//   busy, done                  - burst running / one-cycle completion pulse
module usr_burst_shifter
   import usr_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH+1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] in,
   input  logic             sir,
   input  logic             sil,
   input  logic             burst_start,
   input  logic [CNT_W-1:0] burst_len,
   output logic [WIDTH-1:0] out,
   output logic             so_right,
   output logic             so_left,
   output logic             busy,
   output logic             done
);
   usr_state_t       state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n, len_c;
   logic [2:0]       lmode, lmode_n, step_mode;
   logic [WIDTH-1:0] step_val, out_n;
   logic             done_n, accept;

   assign len_c     = (burst_len > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : burst_len;
   assign accept    = (state == ST_IDLE) && burst_start && is_burstable(mode);
   assign step_mode = (state == ST_BURST) ? lmode : mode;
   assign busy      = (state == ST_BURST);
   assign so_right  = out[0];
   assign so_left   = out[WIDTH-1];

   usr_step_logic #(.WIDTH(WIDTH)) u_step (
      .cur  (out),
      .mode (step_mode),
      .din  (in),
      .sir  (sir),
      .sil  (sil),
      .nxt  (step_val)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
         lmode <= USR_HOLD;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         lmode <= lmode_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      lmode_n = lmode;
      if (state == ST_BURST) begin
         cnt_n   = cnt - CNT_W'(1);
         state_n = (cnt == CNT_W'(1)) ? ST_IDLE : ST_BURST;
      end else if (accept && len_c != '0) begin
         state_n = ST_BURST;
         cnt_n   = len_c;
         lmode_n = mode;
      end
   end

   // A non-burstable burst_start swallows en for that cycle as well
   always_comb begin
      out_n  = out;
      done_n = 1'b0;
      if (state == ST_BURST) begin
         out_n  = step_val;
         done_n = (cnt == CNT_W'(1));
      end else if (accept) begin
         done_n = (len_c == '0);
      end else if (!burst_start && en) begin
         out_n = step_val;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out  <= '0;
         done <= 1'b0;
      end else begin
         out  <= out_n;
         done <= done_n;
      end
   end
endmodule
